mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port synchronous block RAM between the MiniMIPS32 instruction-fetch port and its data port, so the core can run from a unified code+data memory. It sits between `MiniMIPS32` and a single BRAM instance at the system level. Each cycle it grants the RAM to at most one requester and returns read data one cycle later. It also raises a stall request toward the pipeline whenever a requester is refused.

## Interface
Parameters:
- `ADDR_W`, 11: RAM word-address width (RAM depth 2^ADDR_W words).
- `STARVE_MAX`, 4: maximum consecutive data grants allowed while a fetch waits.

Ports:
- `cpu_clk_50M` in 1: the only clock; all state updates on its rising edge.
- `cpu_rst` in 1: synchronous, active-high reset.
- `i_req` in 1: fetch request; held until granted.
- `i_addr` in 32: fetch byte address.
- `i_gnt` out 1: fetch accepted this cycle.
- `i_rvalid` out 1: `i_rdata` is valid this cycle.
- `i_rdata` out 32: fetched instruction.
- `i_err` out 1: the fetch was out of range; pulses with `i_rvalid`.
- `d_req` in 1: data request; held until granted.
- `d_we` in 4: byte write enables; 0 means read.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: write data.
- `d_gnt` out 1: data access accepted this cycle.
- `d_rvalid` out 1: `d_rdata` is valid (reads only).
- `d_rdata` out 32: read data.
- `d_err` out 1: the data access was out of range; pulses one cycle after grant, for reads and writes.
- `mem_en` out 1: RAM enable.
- `mem_we` out 4: RAM byte write enables.
- `mem_addr` out ADDR_W: RAM word address.
- `mem_din` out 32: RAM write data.
- `mem_dout` in 32: RAM read data, valid the cycle after `mem_en`.
- `stall_req` out 1: a request is pending and was not granted this cycle.

## Operation
Arbitration is combinational from the current requests and the registered starvation counter `starve_cnt`.
- **Only one requester:** that requester is granted.
- **Both requesting:** data wins, unless `starve_cnt == STARVE_MAX`; then the fetch wins.
- **Counter update:**
  - `starve_cnt` increments on a cycle with a data grant while `i_req` is refused.
  - It clears on any fetch grant, and on any cycle with `i_req` low.
  - It saturates at `STARVE_MAX`.

Range check:
- An address is in range when `addr[31:ADDR_W+2] == 0`.
- Bits `[1:0]` are ignored (word access; byte selection is done through `d_we`).
- A granted in-range access drives `mem_en=1`, `mem_addr = addr[ADDR_W+1:2]`, `mem_we` (0 for fetch, `d_we` for data) and `mem_din = d_wdata`.
- A granted out-of-range access still asserts its grant, but drives `mem_en=0` and `mem_we=0`.

Response tracking uses a registered tag with states NONE, I_RD, D_RD, I_ERR, D_ERR. It is loaded every cycle as follows:
- **NONE:** no grant, or an in-range data write.
- **I_RD / D_RD:** in-range fetch, or in-range data read.
- **I_ERR / D_ERR:** out-of-range fetch, or out-of-range data access (read or write).

The response outputs are combinational from the tag:
- **I_RD:** `i_rvalid=1`, `i_rdata = mem_dout`.
- **D_RD:** `d_rvalid=1`, `d_rdata = mem_dout`.
- **I_ERR:** `i_rvalid=1`, `i_err=1`, `i_rdata = 0`.
- **D_ERR:** `d_err=1`. `d_rvalid=1` and `d_rdata = 0` only if the access was a read; the tag records read vs write.
- Otherwise `rdata` is 0.

`stall_req = (i_req & ~i_gnt) | (d_req & ~d_gnt)`.

Requester inputs are sampled only in their grant cycle. A requester that changes address while ungranted is served with the new value.

## Timing
- **Grant:** same cycle as the request (0-cycle arbitration); the RAM command is issued in the grant cycle.
- **Read latency:** `rvalid` exactly 1 cycle after grant; one access per cycle, back-to-back at full rate.
- **Write:** completes in the grant cycle; no response except `d_err` for out-of-range.
- **Reset (synchronous):** tag and `starve_cnt` clear at the first clock edge with `cpu_rst=1`. While `cpu_rst=1`, all outputs are forced to 0, regardless of requests.
- **Reset mid-operation:** a response due in the cycle after a reset cycle is dropped; no `rvalid` or `err` appears.
- **Simultaneous read response and new grant:** allowed; the response belongs to the previous grant's tag.
- **Worst-case fetch wait:** `STARVE_MAX` cycles with both requesting.

## Test plan
- **Reset:** `cpu_rst=1` for 2 cycles with `i_req=d_req=1` -> all outputs 0. After release, with no requests, `rvalid`, `err` and `stall_req` stay 0.
- **Fetch-only stream:** addresses 0x0, 0x4, 0x8 on consecutive cycles, with the RAM preloaded word n = 0x1000+n -> `i_gnt=1` each cycle. `i_rvalid` appears one cycle later with 0x1000, 0x1001, 0x1002. `stall_req=0`.
- **Contention:** both request continuously, `STARVE_MAX=4` -> grant pattern D,D,D,D,I repeating. `stall_req=1` every cycle.
- **Write then read:** `d_we=4'b0011` with data 0xAABBCCDD to 0x10 (RAM previously 0x11223344) -> no `d_rvalid`. A following read of 0x10 returns 0x1122CCDD one cycle after its grant.
- **Out of range (`ADDR_W=11`):** fetch of 0x00002000 -> `i_gnt=1` with `mem_en=0`; next cycle `i_rvalid=1`, `i_err=1`, `i_rdata=0`. A data write to 0x00002000 -> `mem_en=0`, `d_err=1` next cycle, `d_rvalid=0`, and RAM unchanged.
- **Reset mid-read:** data read granted, then `cpu_rst=1` on the next edge -> no `d_rvalid` is ever produced for that read. After release, `starve_cnt` restarts from 0, so the first contention gives 4 data grants before a fetch grant.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM bundle shared by the arbiter and its environment.
// The arbiter uses the slave view; the CPU/RAM side uses the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 11
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              i_err;
  logic              d_req;
  logic [3:0]        d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;
  logic              stall_req;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_en, mem_we, mem_addr, mem_din, stall_req
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_en, mem_we, mem_addr, mem_din, stall_req
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port BRAM with bounded fetch starvation.
// Grants are combinational; read data returns one cycle after the grant.
module mem_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int STARVE_MAX = 4
) (
  input logic                cpu_clk_50M,
  input logic                cpu_rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    T_NONE,
    T_I_RD,
    T_D_RD,
    T_I_ERR,
    T_D_ERR
  } tag_e;

  tag_e             tag_q, tag_d;
  logic             rd_q, rd_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic              i_in, d_in, d_rd;
  logic              starve_hit;
  logic              i_gnt, d_gnt;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;

  // Address range, arbitration and RAM command for this cycle.
  always_comb begin
    i_in       = (bus.i_addr[31:ADDR_W+2] == '0);
    d_in       = (bus.d_addr[31:ADDR_W+2] == '0);
    d_rd       = (bus.d_we == 4'b0000);
    starve_hit = (starve_q == CNT_W'(STARVE_MAX));
    i_gnt      = !cpu_rst && bus.i_req
              && (!bus.d_req || starve_hit);
    d_gnt      = !cpu_rst && bus.d_req && !i_gnt;
    mem_en     = 1'b0;
    mem_we     = 4'b0000;
    mem_addr   = '0;
    if (i_gnt) begin
      mem_en   = i_in;
      mem_addr = bus.i_addr[ADDR_W+1:2];
    end else if (d_gnt) begin
      mem_en   = d_in;
      mem_we   = d_in ? bus.d_we : 4'b0000;
      mem_addr = bus.d_addr[ADDR_W+1:2];
    end
  end

  // Next starvation count and response tag.
  always_comb begin
    starve_d = starve_q;
    tag_d    = T_NONE;
    rd_d     = 1'b0;
    if (cpu_rst || !bus.i_req || i_gnt) begin
      starve_d = '0;
    end else if (d_gnt && !starve_hit) begin
      starve_d = starve_q + 1'b1;
    end
    if (i_gnt) begin
      tag_d = i_in ? T_I_RD : T_I_ERR;
    end else if (d_gnt) begin
      rd_d = d_rd;
      if (!d_in) begin
        tag_d = T_D_ERR;
      end else if (d_rd) begin
        tag_d = T_D_RD;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      tag_q    <= T_NONE;
      rd_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      tag_q    <= tag_d;
      rd_q     <= rd_d;
      starve_q <= starve_d;
    end
  end

  // Response outputs decoded from the previous cycle's tag.
  always_comb begin
    bus.i_rvalid = 1'b0;
    bus.i_err    = 1'b0;
    bus.i_rdata  = '0;
    bus.d_rvalid = 1'b0;
    bus.d_err    = 1'b0;
    bus.d_rdata  = '0;
    if (!cpu_rst) begin
      unique case (tag_q)
        T_I_RD: begin
          bus.i_rvalid = 1'b1;
          bus.i_rdata  = bus.mem_dout;
        end
        T_D_RD: begin
          bus.d_rvalid = 1'b1;
          bus.d_rdata  = bus.mem_dout;
        end
        T_I_ERR: begin
          bus.i_rvalid = 1'b1;
          bus.i_err    = 1'b1;
        end
        T_D_ERR: begin
          bus.d_err    = 1'b1;
          bus.d_rvalid = rd_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_din   = cpu_rst ? 32'h0 : bus.d_wdata;
  assign bus.stall_req = !cpu_rst
                      && ((bus.i_req && !i_gnt)
                      ||  (bus.d_req && !d_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter.
// A word-level memory model predicts grants, RAM commands and responses.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 11;
  localparam int SMAX   = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .STARVE_MAX(SMAX)
  ) dut (
    .cpu_clk_50M(clk),
    .cpu_rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b])
          ram[bus.mem_addr][8*b +: 8] <= bus.mem_din[8*b +: 8];
      bus.mem_dout <= ram[bus.mem_addr];
    end
  end

  typedef struct packed {
    logic        i_gnt;
    logic        d_gnt;
    logic        stall;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_din;
    logic        i_rvalid;
    logic        i_err;
    logic [31:0] i_rdata;
    logic        d_rvalid;
    logic        d_err;
    logic [31:0] d_rdata;
  } obs_t;

  obs_t exp_o, act_o;
  int   n_total, n_pass;

  int          m_cnt;
  logic        p_iv, p_ie, p_dv, p_de;
  logic [31:0] p_id, p_dd;

  task automatic cycle(
    input logic        r,
    input logic        ir,
    input logic [31:0] ia,
    input logic        dr,
    input logic [3:0]  dwe,
    input logic [31:0] da,
    input logic [31:0] dwd
  );
    logic        gi, gd, iin, din;
    logic        n_iv, n_ie, n_dv, n_de;
    logic [31:0] n_id, n_dd;
    int          wi, wd;
    rst         = r;
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    #4;
    iin   = ia < 32'h2000;
    din   = da < 32'h2000;
    wi    = int'(ia / 4) % DEPTH;
    wd    = int'(da / 4) % DEPTH;
    gi    = 1'b0;
    gd    = 1'b0;
    exp_o = '0;
    if (!r) begin
      gi = ir && (!dr || m_cnt == SMAX);
      gd = dr && !gi;
      exp_o.i_gnt = gi;
      exp_o.d_gnt = gd;
      exp_o.stall = (ir && !gi) || (dr && !gd);
      if (gi && iin) begin
        exp_o.mem_en   = 1'b1;
        exp_o.mem_addr = 11'(wi);
      end
      if (gd && din) begin
        exp_o.mem_en   = 1'b1;
        exp_o.mem_we   = dwe;
        exp_o.mem_addr = 11'(wd);
        if (dwe != 0) exp_o.mem_din = dwd;
      end
      exp_o.i_rvalid = p_iv;
      exp_o.i_err    = p_ie;
      exp_o.i_rdata  = p_id;
      exp_o.d_rvalid = p_dv;
      exp_o.d_err    = p_de;
      exp_o.d_rdata  = p_dd;
    end
    act_o.i_gnt    = bus.i_gnt;
    act_o.d_gnt    = bus.d_gnt;
    act_o.stall    = bus.stall_req;
    act_o.mem_en   = bus.mem_en;
    act_o.mem_we   = bus.mem_we;
    act_o.mem_addr = bus.mem_en ? bus.mem_addr : '0;
    act_o.mem_din  = (bus.mem_en && bus.mem_we != 0) ? bus.mem_din : '0;
    act_o.i_rvalid = bus.i_rvalid;
    act_o.i_err    = bus.i_err;
    act_o.i_rdata  = bus.i_rdata;
    act_o.d_rvalid = bus.d_rvalid;
    act_o.d_err    = bus.d_err;
    act_o.d_rdata  = bus.d_rdata;
    n_iv = 0; n_ie = 0; n_dv = 0; n_de = 0;
    n_id = 0; n_dd = 0;
    if (r) begin
      m_cnt = 0;
    end else begin
      if (gi) begin
        n_iv = 1'b1;
        if (iin) n_id = ref_mem[wi];
        else     n_ie = 1'b1;
      end
      if (gd) begin
        if (!din) begin
          n_de = 1'b1;
          n_dv = (dwe == 0);
        end else if (dwe == 0) begin
          n_dv = 1'b1;
          n_dd = ref_mem[wd];
        end else begin
          for (int b = 0; b < 4; b++)
            if (dwe[b]) ref_mem[wd][8*b +: 8] = dwd[8*b +: 8];
        end
      end
      if (!ir || gi) m_cnt = 0;
      else if (m_cnt < SMAX) m_cnt = m_cnt + 1;
    end
    p_iv = n_iv; p_ie = n_ie; p_id = n_id;
    p_dv = n_dv; p_de = n_de; p_dd = n_dd;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int k = 0; k < 5; k++) begin
      cycle(k < 2, k < 2, 32'h4, k < 2, 4'h0, 32'h8, 32'h0);
      n_total++;
      if (act_o !== exp_o)
        $display("FAIL reset k=%0d act=%h exp=%h", k, act_o, exp_o);
      else n_pass++;
      n_total++;
      if (k < 2 && act_o !== '0)
        $display("FAIL reset_zero k=%0d act=%h exp=0", k, act_o);
      else n_pass++;
    end
  endtask

  task automatic test_fetch_stream;
    for (int k = 0; k < 4; k++) begin
      cycle(0, k < 3, 32'(4 * k), 0, 4'h0, 0, 0);
      n_total++;
      if (act_o !== exp_o)
        $display("FAIL fetch k=%0d act=%h exp=%h", k, act_o, exp_o);
      else n_pass++;
      if (k > 0) begin
        n_total++;
        if (act_o.i_rdata !== 32'h1000 + 32'(k - 1) || !act_o.i_rvalid
            || act_o.stall)
          $display("FAIL fetch_data k=%0d act=%h exp=%h", k,
                   act_o.i_rdata, 32'h1000 + 32'(k - 1));
        else n_pass++;
      end
    end
  endtask

  task automatic test_contention;
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, 32'($urandom_range(0, 511)) << 2, 1, 4'h0,
            32'($urandom_range(0, 511)) << 2, $urandom);
      n_total++;
      if (act_o !== exp_o)
        $display("FAIL contention k=%0d act=%h exp=%h", k, act_o, exp_o);
      else n_pass++;
      n_total++;
      if (act_o.d_gnt !== (k % 5 != 4) || act_o.i_gnt !== (k % 5 == 4)
          || act_o.stall !== 1'b1)
        $display("FAIL contention_pattern k=%0d act=%b%b exp_d=%b", k,
                 act_o.d_gnt, act_o.i_gnt, k % 5 != 4);
      else n_pass++;
    end
    cycle(0, 0, 0, 0, 4'h0, 0, 0);
  endtask

  task automatic test_write_read;
    cycle(0, 0, 0, 1, 4'b0011, 32'h10, 32'hAABBCCDD);
    n_total++;
    if (act_o !== exp_o)
      $display("FAIL wr_write act=%h exp=%h", act_o, exp_o);
    else n_pass++;
    cycle(0, 0, 0, 1, 4'h0, 32'h10, 0);
    n_total++;
    if (act_o !== exp_o || act_o.d_rvalid)
      $display("FAIL wr_read act=%h exp=%h", act_o, exp_o);
    else n_pass++;
    cycle(0, 0, 0, 0, 4'h0, 0, 0);
    n_total++;
    if (act_o.d_rdata !== 32'h1122CCDD || act_o.d_rvalid !== 1'b1)
      $display("FAIL wr_data act=%h exp=%h", act_o.d_rdata, 32'h1122CCDD);
    else n_pass++;
  endtask

  task automatic test_out_of_range;
    cycle(0, 1, 32'h2000, 0, 4'h0, 0, 0);
    n_total++;
    if (act_o !== exp_o || !act_o.i_gnt || act_o.mem_en)
      $display("FAIL oor_fetch act=%h exp=%h", act_o, exp_o);
    else n_pass++;
    cycle(0, 0, 0, 1, 4'hF, 32'h2000, 32'hDEADBEEF);
    n_total++;
    if (act_o !== exp_o || !act_o.i_err || !act_o.i_rvalid
        || act_o.i_rdata !== 0 || act_o.mem_en)
      $display("FAIL oor_ierr act=%h exp=%h", act_o, exp_o);
    else n_pass++;
    cycle(0, 0, 0, 1, 4'h0, 32'h0, 0);
    n_total++;
    if (act_o !== exp_o || !act_o.d_err || act_o.d_rvalid)
      $display("FAIL oor_derr act=%h exp=%h", act_o, exp_o);
    else n_pass++;
    cycle(0, 0, 0, 0, 4'h0, 0, 0);
    n_total++;
    if (act_o !== exp_o || act_o.d_rdata !== 32'h1000)
      $display("FAIL oor_unchanged act=%h exp=%h", act_o.d_rdata,
               32'h1000);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read;
    cycle(0, 0, 0, 1, 4'h0, 32'h8, 0);
    cycle(1, 0, 0, 0, 4'h0, 0, 0);
    n_total++;
    if (act_o !== exp_o || act_o.d_rvalid)
      $display("FAIL midrst_drop act=%h exp=%h", act_o, exp_o);
    else n_pass++;
    cycle(0, 0, 0, 0, 4'h0, 0, 0);
    n_total++;
    if (act_o !== exp_o || act_o.d_rvalid)
      $display("FAIL midrst_after act=%h exp=%h", act_o, exp_o);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1, 32'h20, 1, 4'h0, 32'h24, 0);
      n_total++;
      if (act_o !== exp_o || act_o.i_gnt !== (k == 4))
        $display("FAIL midrst_starve k=%0d act=%h exp=%h", k, act_o,
                 exp_o);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [31:0] ia, da;
    for (int k = 0; k < 400; k++) begin
      ia = ($urandom_range(0, 7) == 0) ? $urandom
         : 32'($urandom_range(0, 8191));
      da = ($urandom_range(0, 7) == 0) ? $urandom
         : 32'($urandom_range(0, 8191));
      cycle($urandom_range(0, 39) == 0, 1'($urandom), ia,
            1'($urandom), ($urandom_range(0, 1) == 0) ? 4'h0
                          : 4'($urandom), da, $urandom);
      n_total++;
      if (act_o !== exp_o)
        $display("FAIL random k=%0d act=%h exp=%h", k, act_o, exp_o);
      else n_pass++;
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    m_cnt   = 0;
    p_iv = 0; p_ie = 0; p_dv = 0; p_de = 0;
    p_id = 0; p_dd = 0;
    for (int w = 0; w < DEPTH; w++) begin
      ram[w]     = 32'h1000 + 32'(w);
      ref_mem[w] = 32'h1000 + 32'(w);
    end
    ram[4]     = 32'h11223344;
    ref_mem[4] = 32'h11223344;
    bus.mem_dout = '0;
    rst         = 1'b1;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = '0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    @(posedge clk);
    #1;
    test_reset;
    test_fetch_stream;
    test_contention;
    test_write_read;
    test_out_of_range;
    test_reset_mid_read;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
